arith_result_fifo: RTL and testbench
====================================

// Module: arith_result_fifo
// PURPOSE
//  Downstream buffering stage for the 8-bit multiply/divide function unit.
//  - Captures each {mult_result, div_result, div-by-zero flag} triple through a valid/ready handshake.
//  - Holds the triples in a show-ahead FIFO and releases them in order to the consumer.
//  - Decouples the combinational arithmetic from a consumer that may stall.
//  - Keeps a saturating count of divide-by-zero results accepted.
// PARAMETERS
//  DATA_W   8   width of each result field
//  DEPTH    4   FIFO entries; power of two, >= 2
//  ZCNT_W   8   width of the divide-by-zero statistic counter
// PORTS
//  clk           in   1                  rising-edge clock
//  rst_n         in   1                  synchronous reset, active-low
//  in_valid      in   1                  producer has a result triple this cycle
//  in_ready      out  1                  FIFO can accept (= !full)
//  mult_in       in   DATA_W             product (already truncated to DATA_W)
//  div_in        in   DATA_W             quotient (0 when divisor was 0)
//  div_zero_in   in   1                  divisor was 0 for this triple
//  out_valid     out  1                  head entry available (= !empty)
//  out_ready     in   1                  consumer takes head this cycle
//  mult_out      out  DATA_W             head product
//  div_out       out  DATA_W             head quotient
//  div_zero_out  out  1                  head divide-by-zero flag
//  count         out  $clog2(DEPTH)+1    entries currently held, 0..DEPTH
//  zero_cnt      out  ZCNT_W             accepted triples with div_zero_in=1, saturating
// BEHAVIOUR
//  Clock and reset
//  - Single clock, clk. Reset is synchronous and active-low: sampled only on the rising edge of clk while rst_n=0.
//  - Reset values: wr_ptr=rd_ptr=0, count=0, zero_cnt=0, out_valid=0, in_ready=1.
//  - Reset values (cont.): mult_out, div_out and div_zero_out read 0.
//  - Reset mid-operation discards every stored entry. The first accepted triple after reset is the only one visible.
//  Handshake
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - Inputs are sampled on the rising edge where push=1.
//  - in_valid may be held with in_ready=0; nothing is captured and nothing is lost.
//  - Payload is don't-care when in_valid=0.
//  FIFO and latency
//  - Storage: DEPTH x (2*DATA_W+1) registers. Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//  - Show-ahead: outputs are driven from mem[rd_ptr] whenever out_valid=1; data outputs are forced to 0 when empty.
//  - Latency: a push into an empty FIFO gives out_valid=1 on the following cycle. There is no same-cycle bypass.
//  Occupancy
//  - count next = count + push - pop. in_ready = (count != DEPTH); out_valid = (count != 0).
//  - Full: in_ready=0, so no push that cycle even if pop=1 (no write-through). in_ready rises the cycle after a pop.
//  - Empty: out_valid=0; out_ready is ignored.
//  - Simultaneous push and pop at 0 < count < DEPTH: count unchanged, both pointers advance.
//  Statistics
//  - zero_cnt increments on push & div_zero_in.
//  - zero_cnt holds at 2^ZCNT_W-1 (no wrap); it clears only on reset.
//  Arithmetic and width
//  - No arithmetic on payload. Fields are stored and returned bit-exact.
//  - count and zero_cnt are unsigned.
//  - The design contains no latches and no combinational path from in_* to out_*.
// TESTING
//  - Reset: hold rst_n=0 for 2 clocks with in_valid=1 -> in_ready=1, out_valid=0, count=0, zero_cnt=0, outputs 0.
//  - Single pass: push {0x0C,0x03,0}, out_ready=1 -> out_valid high next cycle with 0x0C/0x03/0; count 1->0.
//  - Fill and wrap: out_ready=0, push 4 triples {i*0x11} -> count=4, in_ready=0.
//      Pop 2, push 2 more -> output order exact, pointers wrap, no loss or duplication.
//  - Full + simultaneous: at count=4 assert in_valid & out_ready -> pop only, count=3; next cycle push & pop -> count=3.
//  - Div-zero: push 3 triples with div_zero_in=1, div_out=0 -> zero_cnt=3, div_zero_out=1 on each pop.
//      With ZCNT_W=2 push 5 -> zero_cnt=3.
//  - Reset mid-run: count=3, pulse rst_n=0 one clock -> count=0, out_valid=0.
//      Next push of 0xA5 is the first value out.

Source files
------------

// File: rtl/arith_result_fifo.sv
// arith_result_fifo
// Show-ahead result buffer that sits behind the 8-bit multiply/divide unit.
// It takes {product, quotient, divide-by-zero} triples through a valid/ready
// handshake, returns them in order, and keeps a saturating count of accepted
// divide-by-zero results. Outputs come only from registers, so there is no
// combinational path from in_* to out_*.
module arith_result_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ZCNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          mult_in,
  input  logic [DATA_W-1:0]          div_in,
  input  logic                       div_zero_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          mult_out,
  output logic [DATA_W-1:0]          div_out,
  output logic                       div_zero_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic [ZCNT_W-1:0]          zero_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Payload storage, one array per field.
  logic [DATA_W-1:0] mult_mem_q [DEPTH];
  logic [DATA_W-1:0] div_mem_q  [DEPTH];
  logic              zero_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ZCNT_W-1:0] zero_cnt_q, zero_cnt_d;

  logic push;
  logic pop;

  // Handshake qualifiers and next-state for pointers, occupancy and statistics.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_ready   = (count_q != CNT_W'(DEPTH));
    out_valid  = (count_q != '0);
    push       = in_valid & in_ready;
    pop        = out_valid & out_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    zero_cnt_d = zero_cnt_q;

    // Pointers are power-of-two wide, so the natural overflow gives the wrap.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Saturate at all-ones instead of wrapping.
    if (push && div_zero_in && (zero_cnt_q != {ZCNT_W{1'b1}}))
      zero_cnt_d = zero_cnt_q + ZCNT_W'(1);
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      zero_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      zero_cnt_q <= zero_cnt_d;
    end
  end

  // Payload write on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; empty entries are never visible because outputs are masked by out_valid.
    if (rst_n && push) begin
      mult_mem_q[wr_ptr_q] <= mult_in;
      div_mem_q[wr_ptr_q]  <= div_in;
      zero_mem_q[wr_ptr_q] <= div_zero_in;
    end
  end

  // Show-ahead head outputs, forced to zero while empty.
  always_comb begin
    mult_out     = '0;
    div_out      = '0;
    div_zero_out = 1'b0;
    if (count_q != '0) begin
      mult_out     = mult_mem_q[rd_ptr_q];
      div_out      = div_mem_q[rd_ptr_q];
      div_zero_out = zero_mem_q[rd_ptr_q];
    end
  end

  assign count    = count_q;
  assign zero_cnt = zero_cnt_q;

endmodule

// File: tb/tb_arith_result_fifo.sv
// Testbench for arith_result_fifo: directed scenarios plus a randomized run,
// all compared against a queue-based behavioural model.
module tb_arith_result_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [DATA_W-1:0] m;
    logic [DATA_W-1:0] d;
    logic              z;
  } trip_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mult_in;
  logic [DATA_W-1:0] div_in;
  logic              div_zero_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] mult_out;
  logic [DATA_W-1:0] div_out;
  logic              div_zero_out;
  logic [2:0]        count;
  logic [7:0]        zero_cnt;

  logic              in_ready_z2;
  logic              out_valid_z2;
  logic [DATA_W-1:0] mult_out_z2;
  logic [DATA_W-1:0] div_out_z2;
  logic              div_zero_out_z2;
  logic [2:0]        count_z2;
  logic [1:0]        zero_cnt_z2;

  arith_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .mult_in(mult_in), .div_in(div_in), .div_zero_in(div_zero_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mult_out(mult_out), .div_out(div_out), .div_zero_out(div_zero_out),
    .count(count), .zero_cnt(zero_cnt)
  );

  // Narrow-counter instance fed the same traffic, to exercise saturation.
  arith_result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ZCNT_W(2)) dut_z2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_z2),
    .mult_in(mult_in), .div_in(div_in), .div_zero_in(div_zero_in),
    .out_valid(out_valid_z2), .out_ready(out_ready),
    .mult_out(mult_out_z2), .div_out(div_out_z2), .div_zero_out(div_zero_out_z2),
    .count(count_z2), .zero_cnt(zero_cnt_z2)
  );

  always #5 clk = ~clk;

  // Behavioural model
  trip_t model_q[$];
  int    zc8;
  int    zc2;

  int checks = 0;
  int passes = 0;

  // One clock: decide push/pop from the model, advance the edge, update the model.
  task automatic tick();
    bit    do_push, do_pop, do_rst;
    trip_t t;
    do_rst  = !rst_n;
    do_push = in_valid && (model_q.size() < DEPTH);
    do_pop  = out_ready && (model_q.size() > 0);
    t       = '{m: mult_in, d: div_in, z: div_zero_in};
    @(posedge clk);
    if (do_rst) begin
      model_q.delete();
      zc8 = 0;
      zc2 = 0;
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        model_q.push_back(t);
        if (t.z) begin
          if (zc8 < 255) zc8++;
          if (zc2 < 3)   zc2++;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input bit v, input bit r, input logic [7:0] m,
                       input logic [7:0] d, input bit z);
    in_valid    = v;
    out_ready   = r;
    mult_in     = m;
    div_in      = d;
    div_zero_in = z;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 8'hFF, 8'hEE, 1);
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, count, zero_cnt} !== {1'b1, 1'b0, 3'd0, 8'd0}) begin
      $display("FAIL reset_ctrl: got rdy=%b vld=%b cnt=%0d zc=%0d want rdy=1 vld=0 cnt=0 zc=0",
               in_ready, out_valid, count, zero_cnt);
    end else passes++;
    checks++;
    if ({mult_out, div_out, div_zero_out} !== 17'd0) begin
      $display("FAIL reset_data: got %h/%h/%b want 00/00/0", mult_out, div_out, div_zero_out);
    end else passes++;
    rst_n = 1'b1;
    drive(0, 0, 8'h00, 8'h00, 0);
    tick();
  endtask

  task automatic test_single_pass();
    drive(1, 1, 8'h0C, 8'h03, 0);
    tick();
    drive(0, 1, 8'h00, 8'h00, 0);
    checks++;
    if ({out_valid, mult_out, div_out, div_zero_out, count} !== {1'b1, 8'h0C, 8'h03, 1'b0, 3'd1}) begin
      $display("FAIL single_head: got vld=%b %h/%h/%b cnt=%0d want vld=1 0c/03/0 cnt=1",
               out_valid, mult_out, div_out, div_zero_out, count);
    end else passes++;
    tick();
    checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      $display("FAIL single_drain: got vld=%b cnt=%0d want vld=0 cnt=0", out_valid, count);
    end else passes++;
  endtask

  task automatic test_fill_wrap();
    logic [7:0] v;
    for (int i = 1; i <= 4; i++) begin
      v = 8'(i * 'h11);
      drive(1, 0, v, v, 0);
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if ({count, in_ready, out_valid} !== {3'd4, 1'b0, 1'b1}) begin
      $display("FAIL fill_full: got cnt=%0d rdy=%b vld=%b want cnt=4 rdy=0 vld=1",
               count, in_ready, out_valid);
    end else passes++;
    // Pop two
    for (int i = 1; i <= 2; i++) begin
      v = 8'(i * 'h11);
      checks++;
      if ({mult_out, div_out} !== {v, v}) begin
        $display("FAIL fill_pop%0d: got %h/%h want %h/%h", i, mult_out, div_out, v, v);
      end else passes++;
      drive(0, 1, 8'h00, 8'h00, 0);
      tick();
    end
    // Push two more; write pointer wraps
    for (int i = 5; i <= 6; i++) begin
      v = 8'(i * 'h11);
      drive(1, 0, v, v, 0);
      tick();
    end
    checks++;
    if (count !== 3'd4) begin
      $display("FAIL wrap_count: got %0d want 4", count);
    end else passes++;
    // Drain; read pointer wraps
    for (int i = 3; i <= 6; i++) begin
      v = 8'(i * 'h11);
      checks++;
      if ({out_valid, mult_out, div_out} !== {1'b1, v, v}) begin
        $display("FAIL wrap_order%0d: got vld=%b %h/%h want vld=1 %h/%h",
                 i, out_valid, mult_out, div_out, v, v);
      end else passes++;
      drive(0, 1, 8'h00, 8'h00, 0);
      tick();
    end
    checks++;
    if ({out_valid, count} !== {1'b0, 3'd0}) begin
      $display("FAIL wrap_empty: got vld=%b cnt=%0d want vld=0 cnt=0", out_valid, count);
    end else passes++;
  endtask

  task automatic test_full_simul();
    logic [7:0] exp_head [4];
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'(8'h70 + i), 8'(8'h80 + i), 0);
      tick();
    end
    // Full: push is refused, pop proceeds
    drive(1, 1, 8'h99, 8'h98, 0);
    tick();
    checks++;
    if ({count, in_ready, mult_out} !== {3'd3, 1'b1, 8'h71}) begin
      $display("FAIL full_pop_only: got cnt=%0d rdy=%b head=%h want cnt=3 rdy=1 head=71",
               count, in_ready, mult_out);
    end else passes++;
    // Push and pop together at count 3
    tick();
    checks++;
    if ({count, mult_out} !== {3'd3, 8'h72}) begin
      $display("FAIL simul: got cnt=%0d head=%h want cnt=3 head=72", count, mult_out);
    end else passes++;
    exp_head[0] = 8'h72; exp_head[1] = 8'h73; exp_head[2] = 8'h99; exp_head[3] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mult_out !== exp_head[i]) begin
        $display("FAIL simul_drain%0d: got %h want %h", i, mult_out, exp_head[i]);
      end else passes++;
      drive(0, 1, 8'h00, 8'h00, 0);
      tick();
    end
  endtask

  task automatic test_div_zero();
    int zc_before;
    zc_before = zc8;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'($urandom), 8'h00, 1);
      tick();
    end
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if ({zero_cnt, zero_cnt_z2} !== {8'(zc_before + 3), 2'd3}) begin
      $display("FAIL dz_count: got zc=%0d zc2=%0d want zc=%0d zc2=3",
               zero_cnt, zero_cnt_z2, zc_before + 3);
    end else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, div_out, div_zero_out} !== {1'b1, 8'h00, 1'b1}) begin
        $display("FAIL dz_pop%0d: got vld=%b div=%h dz=%b want vld=1 div=00 dz=1",
                 i, out_valid, div_out, div_zero_out);
      end else passes++;
      drive(0, 1, 8'h00, 8'h00, 0);
      tick();
    end
    // Five more; narrow counter must hold at 3
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 8'($urandom), 8'h00, 1);
      tick();
    end
    drive(0, 1, 8'h00, 8'h00, 0);
    tick();
    checks++;
    if ({zero_cnt, zero_cnt_z2, count} !== {8'(zc_before + 8), 2'd3, 3'd0}) begin
      $display("FAIL dz_saturate: got zc=%0d zc2=%0d cnt=%0d want zc=%0d zc2=3 cnt=0",
               zero_cnt, zero_cnt_z2, count, zc_before + 8);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 8'(8'h40 + i), 8'h01, 1);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      $display("FAIL mid_fill: got cnt=%0d want 3", count);
    end else passes++;
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    tick();
    rst_n = 1'b1;
    checks++;
    if ({count, out_valid, zero_cnt, mult_out} !== {3'd0, 1'b0, 8'd0, 8'h00}) begin
      $display("FAIL mid_reset: got cnt=%0d vld=%b zc=%0d head=%h want cnt=0 vld=0 zc=0 head=00",
               count, out_valid, zero_cnt, mult_out);
    end else passes++;
    drive(1, 0, 8'hA5, 8'h5A, 0);
    tick();
    drive(0, 0, 8'h00, 8'h00, 0);
    checks++;
    if ({out_valid, count, mult_out, div_out} !== {1'b1, 3'd1, 8'hA5, 8'h5A}) begin
      $display("FAIL mid_first: got vld=%b cnt=%0d %h/%h want vld=1 cnt=1 a5/5a",
               out_valid, count, mult_out, div_out);
    end else passes++;
    drive(0, 1, 8'h00, 8'h00, 0);
    tick();
  endtask

  task automatic test_random();
    trip_t exp_head;
    int    errs;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 45),
            8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      tick();
      exp_head = (model_q.size() > 0) ? model_q[0] : '0;
      checks++;
      if ({in_ready, out_valid, count, zero_cnt, zero_cnt_z2, count_z2,
           mult_out, div_out, div_zero_out} !==
          {model_q.size() != DEPTH, model_q.size() != 0, 3'(model_q.size()),
           8'(zc8), 2'(zc2), 3'(model_q.size()), exp_head.m, exp_head.d, exp_head.z}) begin
        if (errs < 10)
          $display("FAIL random cyc %0d: got rdy=%b vld=%b cnt=%0d zc=%0d zc2=%0d %h/%h/%b want rdy=%b vld=%b cnt=%0d zc=%0d zc2=%0d %h/%h/%b",
                   c, in_ready, out_valid, count, zero_cnt, zero_cnt_z2,
                   mult_out, div_out, div_zero_out,
                   model_q.size() != DEPTH, model_q.size() != 0, model_q.size(),
                   zc8, zc2, exp_head.m, exp_head.d, exp_head.z);
        errs++;
      end else passes++;
    end
  endtask

  initial begin
    zc8 = 0;
    zc2 = 0;
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    test_reset();
    test_single_pass();
    test_fill_wrap();
    test_full_simul();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
